// File: rtl/sigma_bus_arb2.sv
// Two-master round-robin arbiter for the sigma req/ack/resp bus, with a read-response watchdog.
// Latency: 1-cycle arbitration bubble in IDLE, then ack follows s_ack_i combinationally (min 2 cycles req->ack).
// Backpressure: masters hold req until ack; slave stalls via s_ack_i; a pending read blocks all new grants.
module sigma_bus_arb2 #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_TIMEOUT = 1023,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA = 32'hDEADBEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_ack_o,
  output logic                    m0_resp_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_ack_o,
  output logic                    m1_resp_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_ack_i,
  input  logic                    s_resp_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o,
  output logic                    grant_o
);

  localparam int CNT_WIDTH = (RESP_TIMEOUT < 1) ? 1 : $clog2(RESP_TIMEOUT + 1);
  // The watchdog fires on the RESP_TIMEOUT-th cycle spent waiting, i.e. when the
  // counter (cleared on the ack edge) shows RESP_TIMEOUT-1.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_t;

  state_t               state, state_n;
  logic                 grant, grant_n;
  logic                 last_grant, last_grant_n;
  logic                 err, err_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;

  // Fields of whichever master currently holds the grant.
  logic                    sel_req;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH/8-1:0] sel_be;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Per-cycle handshake events before routing to a master.
  logic                  ack_hit;
  logic                  resp_hit;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  timeout;

  // Select the granted master's request fields.
  always_comb begin
    sel_req   = grant ? m1_req_i   : m0_req_i;
    sel_we    = grant ? m1_we_i    : m0_we_i;
    sel_addr  = grant ? m1_addr_i  : m0_addr_i;
    sel_be    = grant ? m1_be_i    : m0_be_i;
    sel_wdata = grant ? m1_wdata_i : m0_wdata_i;
  end

  // Next-state logic and all bus outputs.
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    err_n        = err;
    cnt_n        = cnt;
    ack_hit      = 1'b0;
    resp_hit     = 1'b0;
    resp_data    = '0;
    timeout      = 1'b0;
    s_req_o      = 1'b0;
    s_we_o       = 1'b0;
    s_addr_o     = '0;
    s_be_o       = '0;
    s_wdata_o    = '0;

    unique case (state)
      ST_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          // Contention goes to the master that did not win last time;
          // a lone requester wins regardless of history.
          grant_n = (m0_req_i && m1_req_i) ? ~last_grant : m1_req_i;
          state_n = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // A granted master that drops req without ack simply parks us here
        // with s_req_o low until it asks again.
        s_req_o   = sel_req;
        s_we_o    = sel_we;
        s_addr_o  = sel_addr;
        s_be_o    = sel_be;
        s_wdata_o = sel_wdata;
        ack_hit   = s_ack_i && sel_req;
        if (ack_hit) begin
          last_grant_n = grant;
          if (!sel_we) begin
            state_n = ST_WAIT_RESP;
            cnt_n   = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_WAIT_RESP: begin
        timeout   = (cnt == CNT_LAST);
        resp_hit  = s_resp_i || timeout;
        // A genuine response in the final watchdog cycle still wins.
        resp_data = (timeout && !s_resp_i) ? TIMEOUT_RDATA : s_rdata_i;
        if (s_resp_i) begin
          state_n = ST_IDLE;
        end else if (timeout) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    m0_ack_o   = ack_hit && !grant;
    m1_ack_o   = ack_hit && grant;
    m0_resp_o  = resp_hit && !grant;
    m1_resp_o  = resp_hit && grant;
    m0_rdata_o = grant ? '0 : resp_data;
    m1_rdata_o = grant ? resp_data : '0;
  end

  // State, grant history, watchdog and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      err        <= err_n;
      cnt        <= cnt_n;
    end
  end

  assign err_o   = err;
  assign grant_o = grant;

endmodule

// File: tb/tb_sigma_bus_arb2.sv
// Bench for sigma_bus_arb2: directed scenarios plus randomized traffic against a transaction-level model.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the falling edge.
// The slave is either scripted per cycle or a random-stall/random-latency responder.
module tb_sigma_bus_arb2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic m0_req, m0_we, m0_ack, m0_resp;
  logic [AW-1:0] m0_addr;
  logic [BW-1:0] m0_be;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic m1_req, m1_we, m1_ack, m1_resp;
  logic [AW-1:0] m1_addr;
  logic [BW-1:0] m1_be;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic s_req, s_we, s_ack, s_resp;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_be;
  logic [DW-1:0] s_wdata, s_rdata;
  logic err, grant;

  logic auto_slv, auto_ack_ok, man_ack;
  assign s_ack = auto_slv ? (s_req & auto_ack_ok) : man_ack;

  int errors = 0;
  int checks = 0;

  sigma_bus_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_TIMEOUT(TO),
                   .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
    .err_o(err), .grant_o(grant)
  );

  task automatic drive_idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
    man_ack = 0; s_resp = 0; s_rdata = '0; auto_slv = 0; auto_ack_ok = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive_idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({s_req, s_we, s_addr, s_be, s_wdata} !== '0) begin
      errors++; $display("FAIL rst_sbus got=%h exp=0", {s_req, s_we, s_addr, s_be, s_wdata});
    end
    checks++;
    if ({m0_ack, m1_ack, m0_resp, m1_resp} !== 4'b0) begin
      errors++; $display("FAIL rst_ackresp got=%b exp=0000", {m0_ack, m1_ack, m0_resp, m1_resp});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== '0) begin
      errors++; $display("FAIL rst_rdata got=%h exp=0", {m0_rdata, m1_rdata});
    end
    checks++;
    if ({err, grant} !== 2'b00) begin
      errors++; $display("FAIL rst_err_grant got=%b exp=00", {err, grant});
    end
  endtask

  task automatic test_write_m0();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      m0_req = (c <= 1); m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'h12345678; m0_be = 4'hF;
      man_ack = (c == 1);
      @(negedge clk);
      checks++;
      if (s_req !== (c == 1)) begin
        errors++; $display("FAIL wr_sreq c=%0d got=%b exp=%b", c, s_req, (c == 1));
      end
      checks++;
      if (m0_ack !== (c == 1)) begin
        errors++; $display("FAIL wr_m0ack c=%0d got=%b exp=%b", c, m0_ack, (c == 1));
      end
      checks++;
      if (m1_ack !== 1'b0) begin
        errors++; $display("FAIL wr_m1ack c=%0d got=%b exp=0", c, m1_ack);
      end
      if (c == 1) begin
        checks++;
        if ({s_we, s_addr, s_wdata, s_be} !== {1'b1, 32'h100, 32'h12345678, 4'hF}) begin
          errors++; $display("FAIL wr_fields got=%b/%h/%h/%h exp=1/100/12345678/f", s_we, s_addr, s_wdata, s_be);
        end
      end
    end
  endtask

  task automatic test_read_m1();
    int n1 = 0, n0 = 0, rc = -1, m0_dirty = 0;
    logic [DW-1:0] rd = '0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      m1_req = (c <= 1); m1_we = 0; m1_addr = 32'h2000; m1_be = 4'hF;
      man_ack = (c == 1);
      s_resp  = (c == 4);
      s_rdata = (c == 4) ? 32'hCAFEF00D : 32'h0BAD0BAD;
      @(negedge clk);
      if (m1_resp) begin n1++; rc = c; rd = m1_rdata; end
      if (m0_resp) n0++;
      if (m0_rdata !== '0) m0_dirty++;
      if (c == 1) begin
        checks++;
        if ({m1_ack, m0_ack, grant} !== 3'b101) begin
          errors++; $display("FAIL rd_ack got=%b exp=101", {m1_ack, m0_ack, grant});
        end
      end
    end
    checks++;
    if (n1 != 1 || rc != 4) begin
      errors++; $display("FAIL rd_resp_pulse got=%0d@%0d exp=1@4", n1, rc);
    end
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rd_data got=%h exp=cafef00d", rd);
    end
    checks++;
    if (n0 != 0 || m0_dirty != 0) begin
      errors++; $display("FAIL rd_m0_quiet got=%0d/%0d exp=0/0", n0, m0_dirty);
    end
  endtask

  task automatic test_alternate();
    int nacks = 0, n0 = 0, n1 = 0;
    int seq[8];
    int cyc[8];
    do_reset();
    @(posedge clk); #1;
    auto_slv = 1; auto_ack_ok = 1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_be = 4'h3; m0_wdata = 32'hA0;
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_be = 4'hC; m1_wdata = 32'hB1;
    for (int c = 0; c < 60 && nacks < 8; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (m0_ack && m1_ack) begin
        errors++; $display("FAIL alt_double_ack c=%0d got=11 exp=one-hot", c);
      end
      if ((m0_ack || m1_ack) && nacks < 8) begin
        seq[nacks] = m1_ack ? 1 : 0;
        cyc[nacks] = c;
        checks++;
        if (s_addr !== (m1_ack ? 32'h20 : 32'h10)) begin
          errors++; $display("FAIL alt_addr c=%0d got=%h exp=%h", c, s_addr, (m1_ack ? 32'h20 : 32'h10));
        end
        if (m1_ack) n1++; else n0++;
        nacks++;
      end
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0; auto_slv = 0;
    checks++;
    if (nacks != 8) begin
      errors++; $display("FAIL alt_timeout got=%0d acks exp=8", nacks);
    end else begin
      checks++;
      if (cyc[0] != 1) begin
        errors++; $display("FAIL alt_first_lat got=%0d exp=1", cyc[0]);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (seq[k] != (k % 2)) begin
          errors++; $display("FAIL alt_order k=%0d got=%0d exp=%0d", k, seq[k], k % 2);
        end
      end
      for (int k = 2; k < 8; k++) begin
        checks++;
        if (cyc[k] - cyc[k-2] != 4) begin
          errors++; $display("FAIL alt_spacing k=%0d got=%0d exp=4", k, cyc[k] - cyc[k-2]);
        end
      end
      checks++;
      if (n0 != 4 || n1 != 4) begin
        errors++; $display("FAIL alt_counts got=%0d/%0d exp=4/4", n0, n1);
      end
    end
  endtask

  task automatic test_read_blocks();
    int m0_first = -1;
    logic m0_done = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      m1_req = (c <= 1); m1_we = 0; m1_addr = 32'h3000; m1_be = 4'hF;
      m0_req = (c >= 1) && !m0_done; m0_we = 1; m0_addr = 32'h40; m0_be = 4'hF; m0_wdata = 32'h55;
      man_ack = (c == 1) || (c >= 6);
      s_resp  = (c == 5);
      s_rdata = 32'h5A5A0001;
      @(negedge clk);
      if (m0_ack && m0_first < 0) begin m0_first = c; m0_done = 1; end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (s_req !== 1'b0) begin
          errors++; $display("FAIL blk_sreq c=%0d got=%b exp=0", c, s_req);
        end
      end
      if (c == 5) begin
        checks++;
        if ({m1_resp, m1_rdata} !== {1'b1, 32'h5A5A0001}) begin
          errors++; $display("FAIL blk_resp got=%b/%h exp=1/5a5a0001", m1_resp, m1_rdata);
        end
      end
    end
    checks++;
    if (m0_first != 7) begin
      errors++; $display("FAIL blk_m0_grant got=%0d exp=7", m0_first);
    end
  endtask

  task automatic test_timeout();
    int n0 = 0, rc = -1, n1r = 0, m1a = -1;
    logic [DW-1:0] rd = '0;
    logic m1_done = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      m0_req = (c <= 1); m0_we = 0; m0_addr = 32'h500; m0_be = 4'hF;
      m1_req = (c >= 10) && !m1_done; m1_we = 1; m1_addr = 32'h600; m1_be = 4'h1; m1_wdata = 32'h66;
      man_ack = (c == 1) || (c >= 11);
      s_resp  = (c == 13);
      s_rdata = 32'h11112222;
      @(negedge clk);
      if (m0_resp) begin n0++; rc = c; rd = m0_rdata; end
      if (m1_resp) n1r++;
      if (m1_ack && m1a < 0) begin m1a = c; m1_done = 1; end
      checks++;
      if (err !== (c >= 10)) begin
        errors++; $display("FAIL to_err c=%0d got=%b exp=%b", c, err, (c >= 10));
      end
    end
    checks++;
    if (n0 != 1 || rc != 9) begin
      errors++; $display("FAIL to_pulse got=%0d@%0d exp=1@9", n0, rc);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL to_rdata got=%h exp=deadbeef", rd);
    end
    checks++;
    if (m1a != 11 || n1r != 0) begin
      errors++; $display("FAIL to_m1_write got=ack@%0d resp=%0d exp=ack@11 resp=0", m1a, n1r);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      m0_req = (c <= 1); m0_we = 0; m0_addr = 32'h700; m0_be = 4'hF;
      man_ack = (c == 1);
      rst     = (c == 3);
      s_resp  = (c == 5);
      s_rdata = 32'h77;
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (err !== 1'b1) begin
          errors++; $display("FAIL rm_err_before got=%b exp=1", err);
        end
      end
      if (c == 4) begin
        checks++;
        if ({s_req, s_we, s_addr, s_be, s_wdata, m0_ack, m1_ack, m0_resp, m1_resp} !== '0) begin
          errors++; $display("FAIL rm_outputs got=%b%b%h exp=0", s_req, m0_resp, s_addr);
        end
        checks++;
        if ({err, grant, m0_rdata, m1_rdata} !== '0) begin
          errors++; $display("FAIL rm_err_grant got=%b/%b/%h exp=0/0/0", err, grant, m0_rdata);
        end
      end
      if (c == 5) begin
        checks++;
        if ({m0_resp, m1_resp} !== 2'b00) begin
          errors++; $display("FAIL rm_late_resp got=%b exp=00", {m0_resp, m1_resp});
        end
      end
    end
  endtask

  task automatic test_random();
    logic          act[2];
    logic          rdo[2];
    logic          t_we[2];
    logic [AW-1:0] t_addr[2];
    logic [BW-1:0] t_be[2];
    logic [DW-1:0] t_wd[2];
    int            since[2];
    int            nack[2];
    logic          ackv[2];
    logic          respv[2];
    logic          pend_v = 0;
    int            pend_cnt = 0;
    logic [DW-1:0] pend_dat = '0;
    int            last_acked = -1, last_ack_n = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; rdo[i] = 0; t_we[i] = 0; t_addr[i] = '0; t_be[i] = '0; t_wd[i] = '0;
      since[i] = 0; nack[i] = 0;
    end
    do_reset();
    auto_slv = 1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && !rdo[i] && n < 2500 && $urandom_range(0, 2) == 0) begin
          act[i]    = 1;
          t_we[i]   = 1'($urandom_range(0, 1));
          t_addr[i] = $urandom;
          t_be[i]   = 4'($urandom_range(1, 15));
          t_wd[i]   = $urandom;
          since[i]  = n;
        end
      end
      m0_req = act[0]; m0_we = t_we[0]; m0_addr = t_addr[0]; m0_be = t_be[0]; m0_wdata = t_wd[0];
      m1_req = act[1]; m1_we = t_we[1]; m1_addr = t_addr[1]; m1_be = t_be[1]; m1_wdata = t_wd[1];
      auto_ack_ok = ($urandom_range(0, 3) != 0);
      if (pend_v && pend_cnt == 0) begin
        s_resp = 1; s_rdata = pend_dat; pend_v = 0;
      end else begin
        s_resp = 0; s_rdata = $urandom;
        if (pend_v) pend_cnt--;
      end
      @(negedge clk);
      if (rdo[0] || rdo[1]) begin
        checks++;
        if (s_req !== 1'b0) begin
          errors++; $display("FAIL rnd_sreq_busy n=%0d got=%b exp=0", n, s_req);
        end
      end
      respv[0] = m0_resp; respv[1] = m1_resp;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (respv[i] !== (s_resp && rdo[i])) begin
          errors++; $display("FAIL rnd_resp m%0d n=%0d got=%b exp=%b", i, n, respv[i], (s_resp && rdo[i]));
        end
        if (s_resp && rdo[i]) begin
          checks++;
          if ((i == 0 ? m0_rdata : m1_rdata) !== s_rdata) begin
            errors++; $display("FAIL rnd_rdata m%0d n=%0d got=%h exp=%h", i, n, (i == 0 ? m0_rdata : m1_rdata), s_rdata);
          end
          rdo[i] = 0;
        end
      end
      ackv[0] = m0_ack; ackv[1] = m1_ack;
      for (int i = 0; i < 2; i++) begin
        if (ackv[i]) begin
          checks++;
          if (!act[i]) begin
            errors++; $display("FAIL rnd_spurious_ack m%0d n=%0d got=1 exp=0", i, n);
          end else begin
            checks++;
            if ({s_we, s_addr, s_be, s_wdata} !== {t_we[i], t_addr[i], t_be[i], t_wd[i]}) begin
              errors++; $display("FAIL rnd_fields m%0d n=%0d got=%h/%h exp=%h/%h", i, n, s_addr, s_wdata, t_addr[i], t_wd[i]);
            end
            if (last_acked == i && act[1-i] && since[1-i] <= last_ack_n) begin
              checks++;
              errors++; $display("FAIL rnd_fairness m%0d n=%0d got=repeat-grant exp=m%0d", i, n, 1 - i);
            end
            act[i] = 0; nack[i]++; last_acked = i; last_ack_n = n;
            if (!t_we[i]) begin
              rdo[i] = 1; pend_v = 1; pend_cnt = $urandom_range(0, 4); pend_dat = $urandom;
            end
          end
        end
      end
    end
    checks++;
    if (act[0] || act[1] || rdo[0] || rdo[1]) begin
      errors++; $display("FAIL rnd_drain got=%b%b%b%b exp=0000", act[0], act[1], rdo[0], rdo[1]);
    end
    checks++;
    if (nack[0] < 20 || nack[1] < 20) begin
      errors++; $display("FAIL rnd_activity got=%0d/%0d exp>=20 each", nack[0], nack[1]);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_write_m0();
    test_read_m1();
    test_alternate();
    test_read_blocks();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
